// File: rtl/fetch_stage_if.sv
// Instruction-memory request channel between the fetch stage and imem.
//   imem_req   : fetch request valid (fetch -> memory)
//   imem_addr  : word-aligned fetch address (fetch -> memory)
//   imem_ready : memory completes the request this cycle (memory -> fetch)
//   imem_rdata : instruction word, valid with imem_ready (memory -> fetch)
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID pipeline register of the pipelined MIPS core.
// Owns the PC, issues valid/ready requests to instruction memory, buffers a
// returned word while the pipeline is stalled and discards the in-flight
// fetch after a decode-stage redirect.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   stallF_i, stallD_i : hold PC / hold IF/ID (hazard unit)
//   redirectD_i        : taken branch/jump resolved in D, target pctargetD_i
//   imem               : request channel to instruction memory (master)
//   pcF_o              : current fetch PC
//   instrD_o, pcplus4D_o, validD_o : IF/ID register contents
//   imem_stall_o       : fetch is waiting on memory
//
// state | meaning
// FETCH | request for pcF outstanding (or issued this cycle)
// HOLD  | word for pcF captured in buffer, waiting for stallF to drop
// DRAIN | un-cancellable wrong-path request in flight; target held in tgt
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          stallF_i,
    input  logic          stallD_i,
    input  logic          redirectD_i,
    input  logic [31:0]   pctargetD_i,
    fetch_stage_if.master imem,
    output logic [31:0]   pcF_o,
    output logic [31:0]   instrD_o,
    output logic [31:0]   pcplus4D_o,
    output logic          validD_o,
    output logic          imem_stall_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    logic        redir_acc;
    logic        word_avail;
    logic [31:0] word;
    logic [31:0] pc_plus4;

    assign redir_acc  = redirectD_i & ~stallD_i;
    assign word_avail = ((state_q == FETCH) & imem.imem_ready) | (state_q == HOLD);
    assign word       = (state_q == HOLD) ? buf_q : imem.imem_rdata;
    assign pc_plus4   = pc_q + 32'd4;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            buf_q     <= 32'h0;
            tgt_q     <= 32'h0;
            instr_q   <= 32'h0;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            tgt_q     <= tgt_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        tgt_d     = tgt_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;

        // IF/ID register
        if (redir_acc) begin
            instr_d   = 32'h0;
            pcplus4_d = 32'h0;
            valid_d   = 1'b0;
        end else if (stallD_i) begin
            instr_d   = instr_q;
            pcplus4_d = pcplus4_q;
            valid_d   = valid_q;
        end else if (word_avail && !stallF_i) begin
            instr_d   = word;
            pcplus4_d = pc_plus4;
            valid_d   = 1'b1;
        end else begin
            instr_d   = 32'h0;
            pcplus4_d = 32'h0;
            valid_d   = 1'b0;
        end

        // PC and fetch state
        unique case (state_q)
            FETCH: begin
                if (imem.imem_ready) begin
                    if (redir_acc) begin
                        pc_d = pctargetD_i;
                    end else if (!stallF_i) begin
                        pc_d = pc_plus4;
                    end else begin
                        buf_d   = imem.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (redir_acc) begin
                    // request already on the bus cannot be withdrawn
                    tgt_d   = pctargetD_i;
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redir_acc) begin
                    pc_d    = pctargetD_i;
                    state_d = FETCH;
                end else if (!stallF_i) begin
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redir_acc) begin
                    tgt_d = pctargetD_i;
                end
                if (imem.imem_ready) begin
                    pc_d    = redir_acc ? pctargetD_i : tgt_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem.imem_req  = ~reset_i & (state_q != HOLD);
    assign imem.imem_addr = pc_q;
    assign imem_stall_o   = ((state_q == FETCH) & ~imem.imem_ready) | (state_q == DRAIN);

    assign pcF_o      = pc_q;
    assign instrD_o   = instr_q;
    assign pcplus4D_o = pcplus4_q;
    assign validD_o   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the fetch pipeline.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF, stallD, redirectD;
    logic [31:0] pctargetD;
    logic [31:0] pcF, instrD, pcplus4D;
    logic        validD, imem_stall;

    fetch_stage_if imem_if ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .stallF_i     (stallF),
        .stallD_i     (stallD),
        .redirectD_i  (redirectD),
        .pctargetD_i  (pctargetD),
        .imem         (imem_if),
        .pcF_o        (pcF),
        .instrD_o     (instrD),
        .pcplus4D_o   (pcplus4D),
        .validD_o     (validD),
        .imem_stall_o (imem_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // reference model: what the fetch pipeline should be holding
    logic [31:0] m_pc = 32'h0;
    bit          m_holding = 0;    // word for m_pc already received, parked
    logic [31:0] m_buf = 32'h0;
    bit          m_draining = 0;   // wrong-path request still outstanding
    logic [31:0] m_tgt = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pp4 = 32'h0;
    bit          m_valid = 0;

    task automatic cyc(input bit rst, input bit sf, input bit sd, input bit rd,
                       input logic [31:0] tg, input bit rdy);
        bit          acc, fetched, avail;
        logic [31:0] w;
        @(negedge clk);
        reset     = rst;
        stallF    = sf;
        stallD    = sd;
        redirectD = rd;
        pctargetD = tg;
        imem_if.imem_ready = rdy;
        imem_if.imem_rdata = rdy ? memword(m_pc) : $urandom;
        #1;
        chk("imem_req", {31'h0, imem_if.imem_req}, {31'h0, !rst && !m_holding});
        if (!rst) begin
            chk("imem_addr", imem_if.imem_addr, m_pc);
            chk("pcF", pcF, m_pc);
            chk("imem_stall", {31'h0, imem_stall},
                {31'h0, m_draining || (!m_holding && !rdy)});
            chk("instrD", instrD, m_instr);
            chk("pcplus4D", pcplus4D, m_pp4);
            chk("validD", {31'h0, validD}, {31'h0, m_valid});
        end
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_holding = 0; m_buf = 32'h0; m_draining = 0;
            m_tgt = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 0;
        end else begin
            acc     = rd && !sd;
            fetched = !m_holding && !m_draining && rdy;
            avail   = fetched || m_holding;
            w       = m_holding ? m_buf : memword(m_pc);
            if (acc) begin
                m_instr = 0; m_pp4 = 0; m_valid = 0;
            end else if (!sd) begin
                if (avail && !sf) begin
                    m_instr = w; m_pp4 = m_pc + 32'd4; m_valid = 1;
                end else begin
                    m_instr = 0; m_pp4 = 0; m_valid = 0;
                end
            end
            if (m_draining) begin
                if (acc) m_tgt = tg;
                if (rdy) begin
                    m_pc = m_tgt;
                    m_draining = 0;
                end
            end else if (acc) begin
                if (avail) begin
                    m_pc = tg; m_holding = 0;
                end else begin
                    m_tgt = tg; m_draining = 1;
                end
            end else if (avail && !sf) begin
                m_pc = m_pc + 32'd4; m_holding = 0;
            end else if (fetched && sf) begin
                m_holding = 1; m_buf = w;
            end
        end
    endtask

    task automatic run_to(input logic [31:0] target);
        int n = 0;
        while (m_pc != target && n < 64) begin
            cyc(0, 0, 0, 0, 32'h0, 1);
            n++;
        end
        chk("run_to_reached", m_pc, target);
    endtask

    initial begin
        reset = 1'b1; stallF = 0; stallD = 0; redirectD = 0; pctargetD = 0;
        imem_if.imem_ready = 0; imem_if.imem_rdata = 0;

        // reset, then zero-wait streaming
        cyc(1, 0, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 0, 32'h0, 0);
        #1;
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_validD", {31'h0, validD}, 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("stream_pcF", pcF, 32'h10);
        chk("stream_instrD", instrD, memword(32'hC));
        chk("stream_pp4", pcplus4D, 32'h10);

        // three wait states on 0x10
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("wait_pcF", pcF, 32'h14);
        chk("wait_instrD", instrD, memword(32'h10));

        // complete 0x20 under stallF/stallD, held 2 cycles
        run_to(32'h20);
        cyc(0, 1, 1, 0, 32'h0, 1);
        cyc(0, 1, 1, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("hold_instrD", instrD, memword(32'h20));
        chk("hold_pcF", pcF, 32'h24);

        // redirect to 0x100 while 0x30 waits, then 0x200 during drain
        run_to(32'h30);
        cyc(0, 0, 0, 1, 32'h100, 0);
        cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'h200, 0);
        cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("drain_addr", imem_if.imem_addr, 32'h200);
        chk("drain_validD", {31'h0, validD}, 32'h0);
        cyc(0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("drain_instrD", instrD, memword(32'h200));

        // PC wrap
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("wrap_addr", imem_if.imem_addr, 32'h0);
        chk("wrap_pp4", pcplus4D, 32'h0);
        chk("wrap_instrD", instrD, memword(32'hFFFF_FFFC));

        // reset mid-wait
        run_to(32'h8);
        cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 0, 32'h0, 0);
        #1;
        chk("midrst_pcF", pcF, 32'h0);
        chk("midrst_validD", {31'h0, validD}, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst, sf, sd, rd, rdy;
            logic [31:0] tg;
            int r;
            rst = ($urandom_range(0, 255) == 0);
            r   = $urandom_range(0, 99);
            sd  = (r < 20);
            sf  = (r < 25);
            rd  = ($urandom_range(0, 9) == 0);
            tg  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 15) == 0) tg = 32'hFFFF_FFFC;
            rdy = ($urandom_range(0, 9) < 7);
            cyc(rst, sf, sd, rd, tg, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
